tow_referee: RTL and testbench

- Match controller for the two-player tug-of-war game.
- Sits between the two synchronized player buttons and the pair of per-player score-keeper instances.
- Turns button levels into one-cycle increment pulses and arbitrates simultaneous presses.
- Freezes the score keepers between rounds via their idle inputs, clears them between games, and counts games won to declare a match winner.

---
 rtl/tow_pkg.sv | 34 +++
 rtl/tow_edge_arb.sv | 86 ++++++++
 rtl/tow_referee.sv | 141 ++++++++++++++
 tb/tb_tow_referee.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
// tow_pkg : shared state, freeze-code and winner encodings for tow_referee
// Rev 1.0
// ============================================================================
package tow_pkg;

  typedef enum logic [1:0] {
    READY      = 2'd0,
    PLAY       = 2'd1,
    HOLD       = 2'd2,
    MATCH_OVER = 2'd3
  } tow_ref_state_e;

  localparam logic [1:0] IDLE_READY = 2'b01;
  localparam logic [1:0] IDLE_PLAY  = 2'b00;
  localparam logic [1:0] IDLE_HOLD  = 2'b10;
  localparam logic [1:0] IDLE_DONE  = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

  function automatic logic [1:0] idle_code(input tow_ref_state_e s);
    case (s)
      READY:      idle_code = IDLE_READY;
      PLAY:       idle_code = IDLE_PLAY;
      HOLD:       idle_code = IDLE_HOLD;
      default:    idle_code = IDLE_DONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tow_edge_arb.sv
`default_nettype none
// ============================================================================
// tow_edge_arb : button edge detect, simultaneous-press cancel and optional
//                per-player re-press lockout (TOW_REF_LOCKOUT_EN)
// Rev 1.0
// ============================================================================
module tow_edge_arb
`ifdef TOW_REF_LOCKOUT_EN
#(
  parameter int LOCKOUT_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
`ifdef TOW_REF_LOCKOUT_EN
  input  logic i_clr,
`endif
  input  logic i_press_l,
  input  logic i_press_r,
  output logic o_grant_l,
  output logic o_grant_r
);

  logic r_press_l_q;
  logic r_press_r_q;
  logic w_rise_l;
  logic w_rise_r;
  logic w_eff_l;
  logic w_eff_r;
  logic w_grant_l;
  logic w_grant_r;

  assign w_rise_l = i_press_l & ~r_press_l_q;
  assign w_rise_r = i_press_r & ~r_press_r_q;

`ifdef TOW_REF_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] c_lock_load = LW'(LOCKOUT_CYCLES);

  logic [LW-1:0] r_lock_l;
  logic [LW-1:0] r_lock_r;

  // A locked player's rise is dropped before arbitration, so it cannot cancel.
  assign w_eff_l = w_rise_l & (r_lock_l == '0);
  assign w_eff_r = w_rise_r & (r_lock_r == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_l <= '0;
      r_lock_r <= '0;
    end else if (i_clr) begin
      r_lock_l <= '0;
      r_lock_r <= '0;
    end else begin
      if (w_grant_l)            r_lock_l <= c_lock_load;
      else if (r_lock_l != '0)  r_lock_l <= r_lock_l - 1'b1;
      if (w_grant_r)            r_lock_r <= c_lock_load;
      else if (r_lock_r != '0)  r_lock_r <= r_lock_r - 1'b1;
    end
  end
`else
  assign w_eff_l = w_rise_l;
  assign w_eff_r = w_rise_r;
`endif

  assign w_grant_l = i_en & w_eff_l & ~w_eff_r;
  assign w_grant_r = i_en & w_eff_r & ~w_eff_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press_l_q <= 1'b0;
      r_press_r_q <= 1'b0;
      o_grant_l   <= 1'b0;
      o_grant_r   <= 1'b0;
    end else begin
      r_press_l_q <= i_press_l;
      r_press_r_q <= i_press_r;
      o_grant_l   <= w_grant_l;
      o_grant_r   <= w_grant_r;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tow_referee.sv
`default_nettype none
// ============================================================================
// tow_referee : tug-of-war match controller (round FSM, hold timer, game
//               counters); re-press lockout enabled by TOW_REF_LOCKOUT_EN
// Rev 1.0
// ============================================================================
module tow_referee
  import tow_pkg::*;
#(
  parameter int GAMES_TO_WIN   = 3,
  parameter int HOLD_CYCLES    = 50,
  parameter int GW             = 4,
  parameter int LOCKOUT_CYCLES = 4
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          press_l,
  input  logic          press_r,
  input  logic          win_l,
  input  logic          win_r,
  output logic          inc_l,
  output logic          inc_r,
  output logic          score_clr,
  output logic [1:0]    idle,
  output logic [GW-1:0] games_l,
  output logic [GW-1:0] games_r,
  output logic [1:0]    match_winner
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] c_hold_load = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] c_target    = GW'(GAMES_TO_WIN);

  if (LOCKOUT_CYCLES < 1 || HOLD_CYCLES < 1 || GAMES_TO_WIN < 1 ||
      GAMES_TO_WIN > (2**GW - 1)) begin : g_param_check
    $error("tow_referee: parameter out of range");
  end

  tow_ref_state_e r_state, w_state_d;
  logic [HW-1:0]  r_hold, w_hold_d;
  logic [GW-1:0]  r_games_l, w_games_l_d;
  logic [GW-1:0]  r_games_r, w_games_r_d;
  logic [1:0]     r_winner, w_winner_d;
  logic           r_clr, w_clr_d;
  logic [1:0]     r_idle;
  logic           w_arb_en;
  logic           w_game_won;

  // Presses coinciding with a win are dropped along with those outside PLAY.
  assign w_arb_en = (r_state == PLAY) & ~win_l & ~win_r;

  tow_edge_arb
`ifdef TOW_REF_LOCKOUT_EN
  #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES))
`endif
  u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_arb_en),
`ifdef TOW_REF_LOCKOUT_EN
    .i_clr     (r_state == READY),
`endif
    .i_press_l (press_l),
    .i_press_r (press_r),
    .o_grant_l (inc_l),
    .o_grant_r (inc_r)
  );

  assign w_game_won = (r_games_l == c_target) || (r_games_r == c_target);

  always_comb begin
    w_state_d   = r_state;
    w_hold_d    = r_hold;
    w_games_l_d = r_games_l;
    w_games_r_d = r_games_r;
    w_winner_d  = r_winner;
    w_clr_d     = 1'b0;
    case (r_state)
      READY: begin
        if (start) w_state_d = PLAY;
      end
      PLAY: begin
        if (win_l || win_r) begin
          w_state_d = HOLD;
          w_hold_d  = c_hold_load;
          if (win_l && !win_r && r_games_l != c_target) w_games_l_d = r_games_l + 1'b1;
          if (win_r && !win_l && r_games_r != c_target) w_games_r_d = r_games_r + 1'b1;
        end
      end
      HOLD: begin
        if (r_hold != '0) begin
          w_hold_d = r_hold - 1'b1;
        end else if (w_game_won) begin
          w_state_d  = MATCH_OVER;
          w_winner_d = (r_games_l == c_target) ? WIN_L : WIN_R;
        end else begin
          w_state_d = READY;
          w_clr_d   = 1'b1;
        end
      end
      default: begin
        if (start) begin
          w_state_d   = READY;
          w_games_l_d = '0;
          w_games_r_d = '0;
          w_winner_d  = WIN_NONE;
          w_clr_d     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= READY;
      r_hold    <= '0;
      r_games_l <= '0;
      r_games_r <= '0;
      r_winner  <= WIN_NONE;
      r_clr     <= 1'b0;
      r_idle    <= IDLE_READY;
    end else begin
      r_state   <= w_state_d;
      r_hold    <= w_hold_d;
      r_games_l <= w_games_l_d;
      r_games_r <= w_games_r_d;
      r_winner  <= w_winner_d;
      r_clr     <= w_clr_d;
      r_idle    <= idle_code(w_state_d);
    end
  end

  assign score_clr    = r_clr;
  assign idle         = r_idle;
  assign games_l      = r_games_l;
  assign games_r      = r_games_r;
  assign match_winner = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_tow_referee.sv
`default_nettype none
// ============================================================================
// tb_tow_referee : directed + random stimulus against a behavioural referee
// Rev 1.0
// ============================================================================
module tb_tow_referee;

  localparam int GAMES_TO_WIN   = 2;
  localparam int HOLD_CYCLES    = 4;
  localparam int GW             = 4;
  localparam int LOCKOUT_CYCLES = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic          press_l;
  logic          press_r;
  logic          win_l;
  logic          win_r;
  logic          inc_l;
  logic          inc_r;
  logic          score_clr;
  logic [1:0]    idle;
  logic [GW-1:0] games_l;
  logic [GW-1:0] games_r;
  logic [1:0]    match_winner;

  int total;
  int bad;

  tow_referee #(
    .GAMES_TO_WIN   (GAMES_TO_WIN),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .GW             (GW),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .press_l      (press_l),
    .press_r      (press_r),
    .win_l        (win_l),
    .win_r        (win_r),
    .inc_l        (inc_l),
    .inc_r        (inc_r),
    .score_clr    (score_clr),
    .idle         (idle),
    .games_l      (games_l),
    .games_r      (games_r),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference referee: phase 0 waiting for start, 1 playing, 2 showing result, 3 match decided.
  int m_phase, m_prev_l, m_prev_r, m_inc_l, m_inc_r, m_clr;
  int m_gl, m_gr, m_win, m_show, m_lock_l, m_lock_r;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int phase_idle(input int ph);
    case (ph)
      0:       return 1;
      1:       return 0;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev_l = 0; m_prev_r = 0; m_inc_l = 0; m_inc_r = 0; m_clr = 0;
    m_gl = 0; m_gr = 0; m_win = 0; m_show = 0; m_lock_l = 0; m_lock_r = 0;
  endtask

  task automatic model_step(input bit s, input bit pl, input bit pr, input bit wl, input bit wr);
    bit rl, rr, el, er, ok;
    rl = pl && (m_prev_l == 0);
    rr = pr && (m_prev_r == 0);
    el = rl;
    er = rr;
`ifdef TOW_REF_LOCKOUT_EN
    el = rl && (m_lock_l == 0);
    er = rr && (m_lock_r == 0);
`endif
    ok = (m_phase == 1) && !wl && !wr;
    m_inc_l = (ok && el && !er) ? 1 : 0;
    m_inc_r = (ok && er && !el) ? 1 : 0;
`ifdef TOW_REF_LOCKOUT_EN
    if (m_phase == 0) begin
      m_lock_l = 0; m_lock_r = 0;
    end else begin
      m_lock_l = (m_inc_l != 0) ? LOCKOUT_CYCLES : (m_lock_l > 0 ? m_lock_l - 1 : 0);
      m_lock_r = (m_inc_r != 0) ? LOCKOUT_CYCLES : (m_lock_r > 0 ? m_lock_r - 1 : 0);
    end
`endif
    m_prev_l = pl;
    m_prev_r = pr;
    m_clr = 0;
    case (m_phase)
      0: if (s) m_phase = 1;
      1: if (wl || wr) begin
           m_phase = 2;
           m_show = HOLD_CYCLES;
           if (wl && !wr && m_gl < GAMES_TO_WIN) m_gl++;
           if (wr && !wl && m_gr < GAMES_TO_WIN) m_gr++;
         end
      2: begin
           m_show--;
           if (m_show == 0) begin
             if (m_gl == GAMES_TO_WIN || m_gr == GAMES_TO_WIN) begin
               m_phase = 3;
               m_win = (m_gl == GAMES_TO_WIN) ? 1 : 2;
             end else begin
               m_phase = 0;
               m_clr = 1;
             end
           end
         end
      default: if (s) begin
           m_phase = 0; m_gl = 0; m_gr = 0; m_win = 0; m_clr = 1;
         end
    endcase
  endtask

  task automatic check_all();
    check_eq("inc_l", inc_l, m_inc_l);
    check_eq("inc_r", inc_r, m_inc_r);
    check_eq("score_clr", score_clr, m_clr);
    check_eq("idle", idle, phase_idle(m_phase));
    check_eq("games_l", games_l, m_gl);
    check_eq("games_r", games_r, m_gr);
    check_eq("match_winner", match_winner, m_win);
  endtask

  task automatic tick(input bit s, input bit pl, input bit pr, input bit wl, input bit wr);
    start = s; press_l = pl; press_r = pr; win_l = wl; win_r = wr;
    @(posedge clk);
    model_step(s, pl, pr, wl, wr);
    #1;
    check_all();
  endtask

  // Called 1 unit after an edge: asserts reset mid-cycle, checks, releases past the negedge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b1;
  endtask

  int n_l, n_r;

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; start = 1'b0; press_l = 1'b0; press_r = 1'b0; win_l = 1'b0; win_r = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Presses in READY are ignored; then a single rise in PLAY.
    tick(0, 1, 0, 0, 0);
    check_eq("ready_press_no_inc", inc_l, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    check_eq("single_inc", inc_l, 1);
    tick(0, 1, 0, 0, 0);
    check_eq("single_inc_one_cycle", inc_l, 0);

    // Simultaneous rise cancels.
    tick(0, 0, 0, 0, 0);
    n_l = 0; n_r = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 0, 0);
      n_l += int'(inc_l); n_r += int'(inc_r);
    end
    check_eq("simul_cancel_l", n_l, 0);
    check_eq("simul_cancel_r", n_r, 0);

    // Held button gives exactly one increment.
    tick(0, 0, 0, 0, 0);
    n_l = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, 0, 0);
      n_l += int'(inc_l);
    end
    check_eq("held_single_inc", n_l, 1);

    // Right wins a game: hold display then clear pulse.
    tick(0, 0, 0, 0, 1);
    check_eq("win_r_games", games_r, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    check_eq("hold_idle", idle, 2'b10);
    tick(0, 0, 0, 0, 0);
    check_eq("hold_clr", score_clr, 1);
    check_eq("hold_back_ready", idle, 2'b01);

    // Left takes two games and the match.
    for (int g = 0; g < 2; g++) begin
      tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      for (int i = 0; i < HOLD_CYCLES; i++) tick(0, 0, 0, 0, 0);
    end
    check_eq("match_winner_l", match_winner, 2'b01);
    check_eq("match_idle", idle, 2'b11);
    tick(0, 1, 0, 0, 0);
    check_eq("over_held", match_winner, 2'b01);
    tick(1, 0, 0, 0, 0);
    check_eq("restart_clr", score_clr, 1);
    check_eq("restart_games", games_l, 0);

    // Reset mid-PLAY with a button held.
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    do_reset();
    check_eq("rst_idle", idle, 2'b01);
    check_eq("rst_inc", inc_l, 0);

`ifdef TOW_REF_LOCKOUT_EN
    tick(1, 0, 0, 0, 0);
    n_l = 0; n_r = 0;
    tick(0, 1, 0, 0, 0); n_l += int'(inc_l);
    tick(0, 0, 0, 0, 0); n_l += int'(inc_l);
    tick(0, 1, 1, 0, 0); n_l += int'(inc_l); n_r += int'(inc_r);
    tick(0, 0, 0, 0, 0); n_l += int'(inc_l); n_r += int'(inc_r);
    check_eq("lockout_l", n_l, 1);
    check_eq("lockout_r_passes", n_r, 1);
`endif

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      bit s, pl, pr, wl, wr;
      s  = ($urandom_range(0, 7) == 0);
      pl = ($urandom_range(0, 2) == 0) ? ~press_l : press_l;
      pr = ($urandom_range(0, 2) == 0) ? ~press_r : press_r;
      wl = ($urandom_range(0, 19) == 0);
      wr = ($urandom_range(0, 19) == 0);
      tick(s, pl, pr, wl, wr);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
